// File: rtl/ocra_grad_axi_slave.sv
// ocra_grad_axi_slave: AXI4-Lite register port and gradient word FIFO for the gradient controller
// Ports:
//   s00_axi_*     AXI4-Lite slave (write address/data/response, read address/data)
//   grad_en       CTRL[0]
//   grad_div      DIV[9:0]
//   fifo_rd_en    pop request from the gradient serialiser
//   fifo_rd_data  head word, first-word fall-through, 0 while empty
//   fifo_empty    FIFO holds no words
// Register map on addr[4:2]:
//   0 CTRL, 1 DIV, 2 STATUS, 3 DATA push, 4 OVF_CLR
module ocra_grad_axi_slave #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 14,
    parameter int FIFO_AW              = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [3:0]                        s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              grad_en,
    output logic [9:0]                        grad_div,
    input  logic                              fifo_rd_en,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                              fifo_empty
);
    localparam int DW    = C_S00_AXI_DATA_WIDTH;
    localparam int DEPTH = 1 << FIFO_AW;

    logic              awready_q, awready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              ctrl_q, ctrl_d;
    logic [9:0]        div_q, div_d;
    logic              ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]  count_q, count_d;
    logic [DW-1:0]     mem [DEPTH];

    logic [2:0]        wsel, rsel;
    logic              we, re, full, empty, pop, push_req, push, ovf_set;
    logic [DW-1:0]     status, rd_mux;
    logic              unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:5], s00_axi_awaddr[1:0],
                         s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:5], s00_axi_araddr[1:0]};

    always_comb begin
        wsel     = s00_axi_awaddr[4:2];
        rsel     = s00_axi_araddr[4:2];
        // The write commits on the edge that closes the one-cycle ready pulse
        we       = awready_q & s00_axi_awvalid & s00_axi_wvalid;
        re       = arready_q & s00_axi_arvalid;
        empty    = count_q == '0;
        // count never exceeds DEPTH, so its top bit alone marks full
        full     = count_q[FIFO_AW];
        pop      = fifo_rd_en & ~empty;
        push_req = we & (wsel == 3'd3) & (|s00_axi_wstrb);
        // A pop in the same cycle frees the slot a full FIFO needs
        push     = push_req & (~full | pop);
        ovf_set  = push_req & full & ~pop;
        status   = '0;
        status[FIFO_AW:0] = count_q;
        status[16] = empty;
        status[17] = full;
        status[18] = ovf_q;
        rd_mux   = (rsel == 3'd0) ? DW'(ctrl_q) :
                   (rsel == 3'd1) ? DW'(div_q)  :
                   (rsel == 3'd2) ? status      : '0;
        awready_d = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = we | (bvalid_q & ~s00_axi_bready);
        bresp_d   = we ? (ovf_set ? 2'b10 : 2'b00) : bresp_q;
        arready_d = s00_axi_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = re | (rvalid_q & ~s00_axi_rready);
        rdata_d   = re ? rd_mux : rdata_q;
        ctrl_d    = (we && wsel == 3'd0 && s00_axi_wstrb[0]) ? s00_axi_wdata[0] : ctrl_q;
        div_d     = {(we && wsel == 3'd1 && s00_axi_wstrb[1]) ? s00_axi_wdata[9:8] : div_q[9:8],
                     (we && wsel == 3'd1 && s00_axi_wstrb[0]) ? s00_axi_wdata[7:0] : div_q[7:0]};
        // A clear loses to an overflowing push landing on the same edge
        ovf_d     = ovf_set | (ovf_q & ~(we && wsel == 3'd4 && s00_axi_wdata[0]));
        wptr_d    = wptr_q + FIFO_AW'(push);
        rptr_d    = rptr_q + FIFO_AW'(pop);
        count_d   = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= 1'b0;
            div_q     <= '0;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: count and pointers define which entries are live
    always_ff @(posedge s00_axi_aclk) begin
        if (push) mem[wptr_q] <= s00_axi_wdata;
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign grad_en         = ctrl_q;
    assign grad_div        = div_q;
    assign fifo_empty      = empty;
    assign fifo_rd_data    = empty ? '0 : mem[rptr_q];
endmodule
